led_pattern_blinker: RTL and testbench

LED_PATTERN_BLINKER -- requirements
Module: led_pattern_blinker

---
 rtl/led_pattern_blinker.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_blinker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/led_pattern_blinker.sv
// rtl/led_pattern_blinker.sv - multi-channel LED driver with OFF/ON/BLINK/BURST patterns on a shared timebase
module led_pattern_blinker #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRESC    = 1000,
    localparam int CH_W    = $clog2(CHANNELS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_half,
    input  logic [3:0]          cfg_burst,
    output logic                cfg_ack,
    output logic [CHANNELS-1:0] led
);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3} mode_e;
    typedef enum logic [1:0] {B_ON = 2'd0, B_OFF = 2'd1, B_GAP = 2'd2} bst_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic                wr_ok;
    logic                ack_q, ack_d;
    logic [CHANNELS-1:0] led_q, led_d;

    mode_e            mode_q  [CHANNELS];
    mode_e            mode_d  [CHANNELS];
    logic [CNT_W-1:0] half_q  [CHANNELS];
    logic [CNT_W-1:0] half_d  [CHANNELS];
    logic [3:0]       burst_q [CHANNELS];
    logic [3:0]       burst_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_d   [CHANNELS];
    logic [3:0]       pulse_q [CHANNELS];
    logic [3:0]       pulse_d [CHANNELS];
    logic [1:0]       gap_q   [CHANNELS];
    logic [1:0]       gap_d   [CHANNELS];
    bst_e             st_q    [CHANNELS];
    bst_e             st_d    [CHANNELS];

    logic [CNT_W-1:0] half_eff;
    logic [3:0]       burst_eff;
    logic             expire;

    always_comb begin
        tick      = (presc_q == PW'(PRESC - 1));
        presc_d   = tick ? '0 : presc_q + 1'b1;
        wr_ok     = cfg_we && (32'(cfg_ch) < CHANNELS);
        ack_d     = wr_ok;
        led_d     = led_q;
        half_eff  = '0;
        burst_eff = '0;
        expire    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]  = mode_q[i];
            half_d[i]  = half_q[i];
            burst_d[i] = burst_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = pulse_q[i];
            gap_d[i]   = gap_q[i];
            st_d[i]    = st_q[i];
            // A zero field behaves as one so a channel can never stall.
            half_eff   = (half_q[i] == '0) ? CNT_W'(1) : half_q[i];
            burst_eff  = (burst_q[i] == 4'd0) ? 4'd1 : burst_q[i];
            expire     = tick && (cnt_q[i] == half_eff - CNT_W'(1));
            if (wr_ok && (cfg_ch == CH_W'(i))) begin
                mode_d[i]  = mode_e'(cfg_mode);
                half_d[i]  = cfg_half;
                burst_d[i] = cfg_burst;
                cnt_d[i]   = '0;
                pulse_d[i] = '0;
                gap_d[i]   = '0;
                st_d[i]    = B_ON;
                led_d[i]   = (cfg_mode != 2'd0);
            end else begin
                case (mode_q[i])
                    M_OFF: led_d[i] = 1'b0;
                    M_ON:  led_d[i] = 1'b1;
                    M_BLINK: begin
                        if (expire) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else if (tick) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        if (expire) begin
                            cnt_d[i] = '0;
                            case (st_q[i])
                                B_ON: begin
                                    st_d[i]    = B_OFF;
                                    led_d[i]   = 1'b0;
                                    pulse_d[i] = pulse_q[i] + 1'b1;
                                end
                                B_OFF: begin
                                    if (pulse_q[i] < burst_eff) begin
                                        st_d[i]  = B_ON;
                                        led_d[i] = 1'b1;
                                    end else begin
                                        st_d[i]  = B_GAP;
                                        led_d[i] = 1'b0;
                                        gap_d[i] = '0;
                                    end
                                end
                                B_GAP: begin
                                    if (gap_q[i] == 2'd3) begin
                                        st_d[i]    = B_ON;
                                        led_d[i]   = 1'b1;
                                        pulse_d[i] = '0;
                                        gap_d[i]   = '0;
                                    end else begin
                                        gap_d[i] = gap_q[i] + 1'b1;
                                    end
                                end
                                default: begin
                                    st_d[i]  = B_ON;
                                    led_d[i] = 1'b1;
                                end
                            endcase
                        end else if (tick) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ack_q   <= 1'b0;
            led_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]  <= M_OFF;
                half_q[i]  <= '0;
                burst_q[i] <= '0;
                cnt_q[i]   <= '0;
                pulse_q[i] <= '0;
                gap_q[i]   <= '0;
                st_q[i]    <= B_ON;
            end
        end else begin
            presc_q <= presc_d;
            ack_q   <= ack_d;
            led_q   <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]  <= mode_d[i];
                half_q[i]  <= half_d[i];
                burst_q[i] <= burst_d[i];
                cnt_q[i]   <= cnt_d[i];
                pulse_q[i] <= pulse_d[i];
                gap_q[i]   <= gap_d[i];
                st_q[i]    <= st_d[i];
            end
        end
    end

    assign cfg_ack = ack_q;
    assign led     = led_q;
endmodule

// File: tb/tb_led_pattern_blinker.sv
// tb/tb_led_pattern_blinker.sv - table-driven bench for led_pattern_blinker
module tb_led_pattern_blinker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_half = '0;
    logic [3:0]  cfg_burst = '0;
    logic        cfg_ack;
    logic [3:0]  led;

    int n_chk = 0;
    int n_fail = 0;

    led_pattern_blinker #(.CHANNELS(4), .CNT_W(16), .PRESC(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst),
        .cfg_ack(cfg_ack), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  ch;
        logic [1:0]  mode;
        logic [15:0] half;
        logic [3:0]  burst;
        logic [3:0]  led;
        logic        ack;
    } vec_t;

    vec_t tbl[41];

    function automatic vec_t mk(input logic we, input logic [2:0] ch, input logic [1:0] mode,
                                input logic [15:0] half, input logic [3:0] burst,
                                input logic [3:0] l, input logic a);
        vec_t v;
        v.we = we; v.ch = ch; v.mode = mode; v.half = half; v.burst = burst; v.led = l; v.ack = a;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic run_row(input int k);
        cfg_we    = tbl[k].we;
        cfg_ch    = tbl[k].ch;
        cfg_mode  = tbl[k].mode;
        cfg_half  = tbl[k].half;
        cfg_burst = tbl[k].burst;
        @(posedge clk);
        @(negedge clk);
        check("led", k, 16'(led), 16'(tbl[k].led));
        check("cfg_ack", k, 16'(cfg_ack), 16'(tbl[k].ack));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Edges counted from reset release; ticks land on even edges (PRESC=2).
        tbl[0]  = mk(1, 0, 2, 3, 0, 4'b0001, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 4'b0001, 0);
        tbl[2]  = mk(1, 5, 1, 0, 0, 4'b0001, 0);
        tbl[3]  = mk(1, 1, 3, 1, 2, 4'b0011, 1);
        tbl[4]  = mk(1, 2, 2, 0, 0, 4'b0111, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 4'b0000, 0);
        tbl[6]  = mk(0, 0, 1, 5, 0, 4'b0000, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 4'b0110, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 4'b0110, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 4'b0000, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 4'b0000, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 4'b0101, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 4'b0101, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 4'b0001, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 4'b0001, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 4'b0101, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 4'b0101, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 4'b0000, 0);
        tbl[18] = mk(1, 3, 2, 2, 0, 4'b1000, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 4'b1110, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 4'b1110, 0);
        tbl[21] = mk(1, 0, 2, 3, 0, 4'b0001, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 4'b0001, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 4'b0111, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 4'b0111, 0);
        tbl[25] = mk(0, 0, 0, 0, 0, 4'b1001, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 4'b1001, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 4'b1100, 0);
        tbl[28] = mk(0, 0, 0, 0, 0, 4'b1100, 0);
        for (int k = 29; k < 37; k++) tbl[k] = mk(0, 0, 0, 0, 0, 4'b0000, 0);
        tbl[37] = mk(1, 1, 1, 0, 0, 4'b0010, 1);
        tbl[38] = mk(1, 3, 0, 0, 0, 4'b0010, 1);
        tbl[39] = mk(0, 0, 0, 0, 0, 4'b0010, 0);
        tbl[40] = mk(0, 0, 0, 0, 0, 4'b0010, 0);

        @(negedge clk);
        @(negedge clk);
        check("reset_led", -1, 16'(led), 16'h0);
        check("reset_ack", -1, 16'(cfg_ack), 16'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 29; k++) run_row(k);

        // Asynchronous reset between edges, while channels are active.
        cfg_we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led", -2, 16'(led), 16'h0);
        check("async_reset_ack", -2, 16'(cfg_ack), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 29; k < 41; k++) run_row(k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
